// File: rtl/exp3_fluxo_dados_pkg.sv
// rtl/exp3_fluxo_dados_pkg.sv - shared widths and ROM contents for the exp3 datapath
package exp3_fluxo_dados_pkg;

  localparam int LARGURA      = 4;
  localparam int PROFUNDIDADE = 16;

  localparam logic [LARGURA-1:0] ROM_INICIAL [PROFUNDIDADE] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };

endpackage

// File: rtl/exp3_rom_16x4.sv
// rtl/exp3_rom_16x4.sv - 16x4 combinational-read ROM holding the reference sequence
module exp3_rom_16x4
  import exp3_fluxo_dados_pkg::*;
(
  input  logic [3:0] endereco,
  output logic [3:0] dado
);

  assign dado = ROM_INICIAL[endereco];

endmodule

// File: rtl/exp3_fluxo_dados.sv
// rtl/exp3_fluxo_dados.sv - address counter, switch register, ROM and comparator
module exp3_fluxo_dados #(
  parameter int LARGURA      = exp3_fluxo_dados_pkg::LARGURA,
  parameter int PROFUNDIDADE = exp3_fluxo_dados_pkg::PROFUNDIDADE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zeraC,
  input  logic               contaC,
  input  logic               zeraR,
  input  logic               registraR,
  input  logic [LARGURA-1:0] chaves,
  output logic               fimC,
  output logic               chavesIgualMemoria,
  output logic               chavesMaiorMemoria,
  output logic               chavesMenorMemoria,
  output logic [LARGURA-1:0] db_contagem,
  output logic [LARGURA-1:0] db_memoria,
  output logic [LARGURA-1:0] db_chaves
);

  logic [LARGURA-1:0] contagem;
  logic [LARGURA-1:0] registro;
  logic [LARGURA-1:0] memoria;

  // Clears take priority over count/load so the controller can reset mid-scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       contagem <= '0;
    else if (zeraC)  contagem <= '0;
    else if (contaC) contagem <= contagem + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          registro <= '0;
    else if (zeraR)     registro <= '0;
    else if (registraR) registro <= chaves;
  end

  exp3_rom_16x4 u_rom (
    .endereco (contagem),
    .dado     (memoria)
  );

  assign fimC               = (contagem == LARGURA'(PROFUNDIDADE - 1));
  assign chavesIgualMemoria = (registro == memoria);
  assign chavesMaiorMemoria = (registro >  memoria);
  assign chavesMenorMemoria = (registro <  memoria);

  assign db_contagem = contagem;
  assign db_memoria  = memoria;
  assign db_chaves   = registro;

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// tb/tb_exp3_fluxo_dados.sv - directed scoreboard bench for exp3_fluxo_dados
module tb_exp3_fluxo_dados;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zeraC = 1'b0;
  logic       contaC = 1'b0;
  logic       zeraR = 1'b0;
  logic       registraR = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       fimC;
  logic       igual;
  logic       maior;
  logic       menor;
  logic [3:0] db_contagem;
  logic [3:0] db_memoria;
  logic [3:0] db_chaves;

  int applied = 0;
  int errors  = 0;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic [3:0] mem;
    logic [3:0] chv;
    logic       fim;
    logic       ig;
    logic       ma;
    logic       me;
  } exp_t;

  exp_t q[$];

  logic [3:0] rom_ref [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                               4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  logic [3:0] m_cnt = 4'h0;
  logic [3:0] m_reg = 4'h0;

  exp3_fluxo_dados dut (
    .clock              (clock),
    .reset              (reset),
    .zeraC              (zeraC),
    .contaC             (contaC),
    .zeraR              (zeraR),
    .registraR          (registraR),
    .chaves             (chaves),
    .fimC               (fimC),
    .chavesIgualMemoria (igual),
    .chavesMaiorMemoria (maior),
    .chavesMenorMemoria (menor),
    .db_contagem        (db_contagem),
    .db_memoria         (db_memoria),
    .db_chaves          (db_chaves)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.cnt = m_cnt;
    e.chv = m_reg;
    e.mem = rom_ref[m_cnt];
    e.fim = (m_cnt == 4'hF);
    e.ig  = (m_reg == rom_ref[m_cnt]);
    e.ma  = (m_reg >  rom_ref[m_cnt]);
    e.me  = (m_reg <  rom_ref[m_cnt]);
    q.push_back(e);
  endtask

  task automatic cmp4(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp_v);
    applied++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = q.pop_front();
    cmp4(e.tag, "contagem", db_contagem, e.cnt);
    cmp4(e.tag, "memoria",  db_memoria,  e.mem);
    cmp4(e.tag, "chaves",   db_chaves,   e.chv);
    cmp4(e.tag, "fim",   {3'b0, fimC},  {3'b0, e.fim});
    cmp4(e.tag, "igual", {3'b0, igual}, {3'b0, e.ig});
    cmp4(e.tag, "maior", {3'b0, maior}, {3'b0, e.ma});
    cmp4(e.tag, "menor", {3'b0, menor}, {3'b0, e.me});
  endtask

  // One clock edge with the given controls; the model advances on the same edge.
  task automatic step(input string tag, input logic zc, input logic cc,
                      input logic zr, input logic rr, input logic [3:0] ch);
    @(negedge clock);
    zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
    @(posedge clock);
    if (zc)      m_cnt = 4'h0;
    else if (cc) m_cnt = m_cnt + 4'h1;
    if (zr)      m_reg = 4'h0;
    else if (rr) m_reg = ch;
    #1;
    push_exp(tag);
    check_out();
  endtask

  initial begin
    // Reset held: counter and register zero, menor set
    #3;
    push_exp("reset_held");
    check_out();
    cmp4("reset_held", "menor_const", {3'b0, menor}, 4'h1);
    @(negedge clock);
    reset = 1'b0;

    // Build some state, then abort asynchronously
    step("pre_load", 1'b0, 1'b1, 1'b0, 1'b1, 4'h5);
    step("pre_cnt",  1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    m_cnt = 4'h0; m_reg = 4'h0;
    push_exp("reset_mid");
    check_out();
    @(negedge clock);
    reset = 1'b0;

    // Counter full sweep and wrap
    step("zeraC", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 1; i <= 15; i++) step($sformatf("conta_%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    cmp4("fim_at_F", "fim", {3'b0, fimC}, 4'h1);
    step("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Clear priority over count and load
    step("cnt_a", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("zera_conta", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step("load9", 1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
    step("zera_registra", 1'b0, 1'b0, 1'b1, 1'b1, 4'h7);

    // Comparator cases
    step("addr0_eq", 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
    step("to1", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("to2", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("to3", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("addr3_lt", 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
    step("addr3_gt", 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    step("conta_and_load", 1'b0, 1'b1, 1'b0, 1'b1, 4'h4);

    // Full scan loading the ROM value at every address
    step("scan_start", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("scan_load_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, rom_ref[i]);
      cmp4($sformatf("scan_eq_%0d", i), "igual", {3'b0, igual}, 4'h1);
      step($sformatf("scan_next_%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    end

    applied++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
